// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO that sits behind a UART receiver. Bytes arrive as
// one-cycle rx_valid strobes and are drained through a valid/ready port.
// Bytes that arrive while the FIFO is full and not draining are dropped.
// A sticky overflow flag and a saturating drop counter record those losses.
// Occupancy is tracked by an explicit counter, so full and empty never
// depend on comparing the two pointers.
module uart_rx_fifo #(
    parameter int BYTESIZES = 8,
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 12
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       rx_valid,
    input  logic [BYTESIZES-1:0]       rx_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BYTESIZES-1:0]       out_data,
    input  logic                       flush,
    input  logic                       clear_overflow,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(THRESHOLD);
    localparam logic [7:0]    DROP_MAX    = 8'hFF;

    // Registered state
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic [7:0]    drop_count_reg, drop_count_next;

    // Storage, flattened so each entry can be driven from its own generate
    // block and still be indexed by the read pointer.
    logic [DEPTH-1:0][BYTESIZES-1:0] mem_flat;

    // Per-cycle handshake decode
    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic rd_en;
    logic drop;

    assign push = rx_valid;
    assign pop  = out_valid & out_ready;
    assign full = (count_reg == FULL_LEVEL);

    // Full with a simultaneous pop still accepts the byte; the slot freed
    // by the pop takes it. Flush cancels both sides, and a byte presented
    // during a flush is simply discarded rather than treated as a drop.
    assign wr_en = push & (~full | pop) & ~flush;
    assign rd_en = pop & ~flush;
    assign drop  = push & full & ~pop & ~flush;

    // Next-state computation for pointers, occupancy and loss tracking
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        overflow_next   = overflow_reg;
        drop_count_next = drop_count_reg;

        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end

        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
        end else begin
            if (rd_en) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count_next = count_reg + CW'(1);
            end else if (rd_en && !wr_en) begin
                count_next = count_reg - CW'(1);
            end
        end

        // A drop in the same cycle as a clear wins, so that loss is never
        // hidden by a clear that the software issued slightly too late.
        if (clear_overflow) begin
            overflow_next   = drop;
            drop_count_next = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_next = 1'b1;
            if (drop_count_reg != DROP_MAX) begin
                drop_count_next = drop_count_reg + 8'd1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= 8'd0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            drop_count_reg <= drop_count_next;
        end
    end

    // One register per entry: every entry must clear on reset, so the
    // storage is built from resettable flops instead of a RAM macro.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            localparam logic [AW-1:0] ENTRY_IDX = AW'(gi);

            logic [BYTESIZES-1:0] entry_reg;

            // Capture the incoming byte when this entry is the write target
            always_ff @(posedge clock or negedge nreset) begin
                if (!nreset) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_ptr_reg == ENTRY_IDX)) begin
                    entry_reg <= rx_data;
                end
            end

            assign mem_flat[gi] = entry_reg;
        end
    endgenerate

    // Outputs are all taken from registered state
    assign out_valid   = (count_reg != '0);
    assign out_data    = mem_flat[rd_ptr_reg];
    assign count       = count_reg;
    assign almost_full = (count_reg >= AFULL_LEVEL);
    assign overflow    = overflow_reg;
    assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with default parameters (8-bit bytes, 16 entries,
// almost_full at 12). A small queue model acts as the scoreboard: accepted
// bytes are pushed when stimulus is driven and popped and compared when the
// DUT hands a byte out. A table of vectors covers the basic ordering case,
// and hand-written sequences cover full, overflow, flush and reset.
module tb_uart_rx_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int THR   = 12;

    logic         clock;
    logic         nreset;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         flush;
    logic         clear_overflow;
    logic [4:0]   count;
    logic         almost_full;
    logic         overflow;
    logic [7:0]   drop_count;

    uart_rx_fifo #(.BYTESIZES(W), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
        .clock          (clock),
        .nreset         (nreset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .count          (count),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Scoreboard / reference model
    logic [W-1:0] mq[$];
    logic         m_ovf;
    int           m_drops;

    typedef struct {
        logic         rv;
        logic [W-1:0] rd;
        logic         rdy;
        int           exp_count;
        logic         exp_valid;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare every observable output with the model
    task automatic check_outputs(input string tag);
        chk({tag, ".count"},       int'(count),       mq.size());
        chk({tag, ".out_valid"},   int'(out_valid),   int'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".out_data"}, int'(out_data), int'(mq[0]));
        chk({tag, ".almost_full"}, int'(almost_full), int'(mq.size() >= THR));
        chk({tag, ".overflow"},    int'(overflow),    int'(m_ovf));
        chk({tag, ".drop_count"},  int'(drop_count),  m_drops);
    endtask

    // One clock cycle: entered and left at posedge+1
    task automatic cycle(input logic rv, input logic [W-1:0] rd, input logic rdy,
                         input logic fl, input logic clr, input string tag);
        logic m_pop, m_full, m_drop;
        rx_valid       = rv;
        rx_data        = rd;
        out_ready      = rdy;
        flush          = fl;
        clear_overflow = clr;
        #3;
        m_pop  = (mq.size() != 0) && rdy;
        m_full = (mq.size() == DEPTH);
        m_drop = 1'b0;
        if (m_pop) begin
            chk({tag, ".pop_data"}, int'(out_data), int'(mq[0]));
            $display("pop  0x%02h  (expected 0x%02h)", out_data, mq[0]);
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (rv && (!m_full || m_pop)) mq.push_back(rd);
            else if (rv) m_drop = 1'b1;
        end
        if (clr) begin
            m_ovf   = m_drop;
            m_drops = m_drop ? 1 : 0;
        end else if (m_drop) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
        @(posedge clock);
        #1;
        rx_valid       = 1'b0;
        out_ready      = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        check_outputs(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".count"},       int'(count),       0);
        chk({tag, ".out_valid"},   int'(out_valid),   0);
        chk({tag, ".out_data"},    int'(out_data),    0);
        chk({tag, ".almost_full"}, int'(almost_full), 0);
        chk({tag, ".overflow"},    int'(overflow),    0);
        chk({tag, ".drop_count"},  int'(drop_count),  0);
    endtask

    initial begin
        mq.delete();
        m_ovf          = 1'b0;
        m_drops        = 0;
        nreset         = 1'b0;
        rx_valid       = 1'b0;
        rx_data        = '0;
        out_ready      = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;

        vecs[0] = '{1'b1, 8'h78, 1'b0, 1, 1'b1, 8'h78};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 2, 1'b1, 8'h78};
        vecs[2] = '{1'b1, 8'h7F, 1'b0, 3, 1'b1, 8'h78};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h01};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h7F};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

        // Reset state
        #1;
        check_zero_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #2;
        nreset = 1'b1;
        @(posedge clock);
        #1;

        // Ordered push then drain, from the vector table
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].rv, vecs[i].rd, vecs[i].rdy, 1'b0, 1'b0, "vec");
            chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d.data", i), int'(out_data), int'(vecs[i].exp_data));
        end

        // Fill to 16; almost_full rises at 12
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, "fill");
            chk($sformatf("fill%0d.af", i), int'(almost_full), int'(i + 1 >= 12));
        end
        chk("full.count", int'(count), 16);
        // 17th push is lost, head stays
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "drop1");
        chk("drop1.overflow", int'(overflow), 1);
        chk("drop1.drop_count", int'(drop_count), 1);
        chk("drop1.head", int'(out_data), 8'h10);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr1");

        // Push and pop together while full
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "fullpp");
        chk("fullpp.count", int'(count), 16);
        chk("fullpp.overflow", int'(overflow), 0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        chk("drain.last", int'(out_data), 8'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
        chk("drain.empty", int'(out_valid), 0);
        // Empty FIFO ignores out_ready
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "emptyrdy");

        // Saturating drop counter
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, "fill2");
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "sat");
        chk("sat.drop_count", int'(drop_count), 255);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr2");
        chk("clr2.drop_count", int'(drop_count), 0);
        chk("clr2.overflow", int'(overflow), 0);
        // Clear coinciding with a drop
        cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, "clrdrop");
        chk("clrdrop.drop_count", int'(drop_count), 1);
        chk("clrdrop.overflow", int'(overflow), 1);

        // Drain to 5 entries then flush with push and pop active
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain5");
        chk("drain5.count", int'(count), 5);
        cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, "flush");
        chk("flush.count", int'(count), 0);
        chk("flush.valid", int'(out_valid), 0);
        chk("flush.overflow", int'(overflow), 1);
        chk("flush.drop_count", int'(drop_count), 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, "pre_rst");
        chk("pre_rst.count", int'(count), 7);
        rx_valid  = 1'b1;
        rx_data   = 8'h99;
        out_ready = 1'b1;
        nreset    = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        @(posedge clock);
        #1;
        check_zero_outputs("rst_edge");
        rx_valid  = 1'b0;
        out_ready = 1'b0;
        nreset    = 1'b1;
        @(posedge clock);
        #1;
        cycle(1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, "post_rst");
        chk("post_rst.data", int'(out_data), 8'h2A);
        chk("post_rst.count", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL take parameter BYTESIZES, default 8: data width in bits, matching the receiver byte size.
REQ-002 The block SHALL take parameter DEPTH, default 16: FIFO entries, a power of two, at least 2.
REQ-003 The block SHALL take parameter THRESHOLD, default 12: the fill level that asserts almost_full, in the range 1..DEPTH.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nreset, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking a received byte from the UART receiver.
REQ-007 The block SHALL have port rx_data, input, BYTESIZES bits: the received byte, sampled when rx_valid=1.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-010 The block SHALL have port out_data, output, BYTESIZES bits: the head entry.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous empty request.
REQ-012 The block SHALL have port clear_overflow, input, 1 bit: clears overflow and drop_count.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port almost_full, output, 1 bit: asserted when count >= THRESHOLD.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, a byte was dropped.
REQ-016 The block SHALL have port drop_count, output, 8 bits: number of dropped bytes, saturating.

Function
REQ-017 The FIFO SHALL treat push = rx_valid, and pop = out_valid & out_ready.
REQ-018 The FIFO SHALL write rx_data at wr_ptr when push and (count<DEPTH or pop), then advance wr_ptr modulo DEPTH.
REQ-019 When pop occurs, the FIFO SHALL advance rd_ptr modulo DEPTH.
REQ-020 The FIFO SHALL leave count unchanged on push+pop, add 1 on push only, and subtract 1 on pop only.
REQ-021 out_valid SHALL equal (count!=0), and out_data SHALL equal mem[rd_ptr] with no added latency.
REQ-022 Write-to-read latency SHALL be 1 cycle: a byte pushed into an empty FIFO at edge N gives out_valid=1 after edge N; there is no same-cycle bypass.
REQ-023 When the FIFO is full and both push and pop occur, the FIFO SHALL store the byte and pop the head, with count staying at DEPTH.
REQ-024 When the FIFO is full, push occurs and there is no pop, the FIFO SHALL drop the byte, leave memory and pointers unchanged, set overflow=1 and increment drop_count, saturating at 255.
REQ-025 When the FIFO is empty, out_ready SHALL be ignored and no pointer SHALL move.
REQ-026 When flush=1, the FIFO SHALL set rd_ptr=wr_ptr and count=0 at the next edge, overriding push and pop that cycle; the flushed byte is not counted as dropped.
REQ-027 clear_overflow SHALL zero overflow and drop_count; if a drop occurs in the same cycle, overflow SHALL be 1 and drop_count SHALL be 1.
REQ-028 almost_full, overflow, count and drop_count SHALL be registered or derived only from registered state, with no combinational path from inputs.
REQ-029 Pointers SHALL be $clog2(DEPTH) bits and wrap naturally; full and empty SHALL be decided by count, never by pointer compare alone.

Reset
REQ-030 While nreset=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_count=0 and all memory entries =0, giving out_valid=0, out_data=0 and almost_full=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored bytes, and the first push after release SHALL be written to entry 0.
REQ-032 No push or pop SHALL take effect on the edge where nreset is sampled low.

Verification
REQ-033 The bench SHALL cover: after reset, push 0x78, 0x01, 0x7F on consecutive cycles with out_ready=0 -> count=3, out_valid=1, out_data=0x78; then out_ready=1 for 3 cycles -> 0x78, 0x01, 0x7F in order, then count=0 and out_valid=0.
REQ-034 The bench SHALL cover: DEPTH=16, push 16 bytes with no pops -> count=16, almost_full=1 from count=12; a 17th push -> byte lost, overflow=1, drop_count=1, head unchanged.
REQ-035 The bench SHALL cover: full FIFO, push 0x55 with out_ready=1 in the same cycle -> old head popped, count stays 16, 0x55 read last after draining, overflow stays 0.
REQ-036 The bench SHALL cover: 300 pushes while full with no pops -> drop_count=255; then clear_overflow=1 for one cycle -> overflow=0, drop_count=0.
REQ-037 The bench SHALL cover: FIFO holding 5 bytes, flush=1 with push and out_ready both high -> count=0, out_valid=0 next cycle, overflow unchanged.
REQ-038 The bench SHALL cover: nreset pulsed low while count=7 and mid-stream -> outputs zero immediately without a clock edge; after release, push 0x2A -> out_data=0x2A next cycle.
